dram_reset_sequencer: RTL and testbench



---
 rtl/dram_rst_pkg.sv | 15 +
 rtl/bit_synchronizer.sv | 25 ++
 rtl/dram_reset_sequencer.sv | 130 +++++++++++++
 tb/tb_dram_reset_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_rst_pkg.sv
// Shared types and default parameters for the DRAM reset sequencer.
package dram_rst_pkg;

  typedef enum logic [2:0] {SYNC, HOLD, WAIT_CAL, RUN, FAIL} dram_rst_state_t;

  localparam int unsigned DEF_RST_SYNC_STAGES      = 2;
  localparam int unsigned DEF_RST_HOLD_CYCLES      = 1024;
  localparam int unsigned DEF_CALIB_TIMEOUT_CYCLES = 16777216;
  localparam int unsigned DEF_MAX_RETRIES          = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop single-bit synchronizer with asynchronous active-low clear
// to a configurable value.
module bit_synchronizer #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rstx,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dram_reset_sequencer.sv
// Power-on / recovery reset sequencer for the DDR3 wrapper: holds sys_rst,
// watches calibration, retries a bounded number of times, then latches failure.
module dram_reset_sequencer
  import dram_rst_pkg::*;
#(
  parameter int unsigned RST_SYNC_STAGES      = DEF_RST_SYNC_STAGES,
  parameter int unsigned RST_HOLD_CYCLES      = DEF_RST_HOLD_CYCLES,
  parameter int unsigned CALIB_TIMEOUT_CYCLES = DEF_CALIB_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES
) (
  input  logic                               clk_166_67_mhz,
  input  logic                               dram_rstx_async,
  input  logic                               init_calib_complete,
  output logic                               sys_rst,
  output logic                               calib_ok,
  output logic                               calib_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int unsigned CNT_W = $clog2(max_u(RST_HOLD_CYCLES, CALIB_TIMEOUT_CYCLES));
  localparam int unsigned RC_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(MAX_RETRIES);

  logic rst_i;
  logic rst_n_i;
  logic cal_s;

  dram_rst_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  retry_d;
  logic             restart;
  logic             sys_rst_d, calib_ok_d, calib_fail_d;

  // Reset synchronizer: set asynchronously, released after a chain of zeros.
  bit_synchronizer #(
    .STAGES      (RST_SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_rst_sync (
    .clk  (clk_166_67_mhz),
    .rstx (dram_rstx_async),
    .d    (1'b0),
    .q    (rst_i)
  );

  assign rst_n_i = ~rst_i;

  bit_synchronizer #(
    .STAGES      (RST_SYNC_STAGES),
    .RESET_VALUE (1'b0)
  ) u_cal_sync (
    .clk  (clk_166_67_mhz),
    .rstx (rst_n_i),
    .d    (init_calib_complete),
    .q    (cal_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_count;
    restart = 1'b0;

    case (state_q)
      // The register is held in SYNC by rst_i, so any clocked cycle here has rst_i=0.
      SYNC: state_d = HOLD;
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_CAL;
        end
      end
      WAIT_CAL: begin
        if (cal_s) begin
          state_d = RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          restart = 1'b1;
        end
      end
      RUN: begin
        if (!cal_s) begin
          restart = 1'b1;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = SYNC;
    endcase

    // Timeout and calibration loss share one bounded-retry policy.
    if (restart) begin
      if (retry_count < RETRY_LIMIT) begin
        state_d = HOLD;
        retry_d = retry_count + 1'b1;
      end else begin
        state_d = FAIL;
      end
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == HOLD || state_q == WAIT_CAL) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    sys_rst_d    = !(state_d == WAIT_CAL || state_d == RUN);
    calib_ok_d   = (state_d == RUN);
    calib_fail_d = (state_d == FAIL);
  end

  always_ff @(posedge clk_166_67_mhz or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      retry_count <= '0;
      sys_rst     <= 1'b1;
      calib_ok    <= 1'b0;
      calib_fail  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_count <= retry_d;
      sys_rst     <= sys_rst_d;
      calib_ok    <= calib_ok_d;
      calib_fail  <= calib_fail_d;
    end
  end

endmodule

// File: tb/tb_dram_reset_sequencer.sv
// Scoreboard bench for dram_reset_sequencer: stimulus queues expected output
// changes with their edge numbers, a negedge monitor matches them.
module tb_dram_reset_sequencer;

  localparam int unsigned STAGES  = 2;
  localparam int unsigned HOLD    = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned RETRIES = 2;

  logic       clk  = 1'b0;
  logic       rstx = 1'b1;
  logic       cal  = 1'b0;
  logic       sys_rst, calib_ok, calib_fail;
  logic [1:0] retry_count;

  dram_reset_sequencer #(
    .RST_SYNC_STAGES      (STAGES),
    .RST_HOLD_CYCLES      (HOLD),
    .CALIB_TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES          (RETRIES)
  ) dut (
    .clk_166_67_mhz      (clk),
    .dram_rstx_async     (rstx),
    .init_calib_complete (cal),
    .sys_rst             (sys_rst),
    .calib_ok            (calib_ok),
    .calib_fail          (calib_fail),
    .retry_count         (retry_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // outs = {sys_rst, calib_ok, calib_fail, retry_count}
  typedef struct {
    int         cyc;
    logic [4:0] outs;
  } ev_t;

  ev_t        exp_q[$];
  logic [4:0] model_out = 5'b10000;
  logic [4:0] mon_prev  = 5'b10000;
  logic [4:0] mon_cur;
  ev_t        mon_e;
  int         checks = 0;
  int         errors = 0;

  task automatic expect_at(input int c, input logic s, input logic o, input logic f,
                           input logic [1:0] r);
    logic [4:0] v;
    v = {s, o, f, r};
    if (v != model_out) begin
      exp_q.push_back('{c, v});
      model_out = v;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [4:0] want);
    logic [4:0] got;
    got = {sys_rst, calib_ok, calib_fail, retry_count};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  // Outputs must reach reset values before any further clock edge.
  task automatic pulse_reset(input string name);
    rstx = 1'b0;
    #1;
    check_now(name, 5'b10000);
    expect_at(cyc, 1'b1, 1'b0, 1'b0, 2'd0);
    tick(2);
  endtask

  task automatic release_reset(output int n);
    rstx = 1'b1;
    n    = cyc;
    expect_at(n + 19, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  always @(negedge clk) begin
    mon_cur = {sys_rst, calib_ok, calib_fail, retry_count};
    if (mon_cur !== mon_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change cycle=%0d got=%b want=%b", cyc, mon_cur, mon_prev);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (mon_cur !== mon_e.outs) begin
          errors++;
          $display("FAIL event_value cycle=%0d got=%b want=%b", cyc, mon_cur, mon_e.outs);
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL event_cycle value=%b got_cycle=%0d want_cycle=%0d",
                   mon_cur, cyc, mon_e.cyc);
        end
      end
    end
    mon_prev = mon_cur;
  end

  initial begin
    int n, e, f, g, r, r2;

    // Power-on reset, then release with calibration arriving on WAIT_CAL entry.
    #2 rstx = 1'b0;
    #1 check_now("power_on_reset", 5'b10000);
    tick(2);
    release_reset(n);
    tick(19);
    e = cyc;
    cal = 1'b1;
    expect_at(e + 3, 1'b0, 1'b1, 1'b0, 2'd0);
    tick(8);

    // Calibration loss in RUN, with calib toggling during the retry HOLD.
    f = cyc;
    cal = 1'b0;
    expect_at(f + 3,  1'b1, 1'b0, 1'b0, 2'd1);
    expect_at(f + 19, 1'b0, 1'b0, 1'b0, 2'd1);
    expect_at(f + 20, 1'b0, 1'b1, 1'b0, 2'd1);
    tick(10); cal = 1'b1;
    tick(2);  cal = 1'b0;
    tick(1);  cal = 1'b1;
    tick(2);  cal = 1'b0;
    tick(1);  cal = 1'b1;
    tick(10);

    // Loss again, then timeout with retries exhausted -> FAIL; late calib ignored.
    g = cyc;
    cal = 1'b0;
    expect_at(g + 3,  1'b1, 1'b0, 1'b0, 2'd2);
    expect_at(g + 19, 1'b0, 1'b0, 1'b0, 2'd2);
    expect_at(g + 83, 1'b1, 1'b0, 1'b1, 2'd2);
    tick(85);
    cal = 1'b1;
    tick(10);
    check_now("fail_sticky", 5'b10110);

    // Reset from FAIL, one timeout retry, then reset in the middle of HOLD.
    cal = 1'b0;
    pulse_reset("reset_in_fail");
    release_reset(n);
    e = n + 19;
    expect_at(e + 64, 1'b1, 1'b0, 1'b0, 2'd1);
    tick(19 + 64 + 8);
    pulse_reset("reset_mid_hold");

    // Full restart: two timeout retries then FAIL.
    release_reset(n);
    e = n + 19;
    expect_at(e + 64,  1'b1, 1'b0, 1'b0, 2'd1);
    expect_at(e + 80,  1'b0, 1'b0, 1'b0, 2'd1);
    expect_at(e + 144, 1'b1, 1'b0, 1'b0, 2'd2);
    expect_at(e + 160, 1'b0, 1'b0, 1'b0, 2'd2);
    expect_at(e + 224, 1'b1, 1'b0, 1'b1, 2'd2);
    tick(19 + 224 + 2);
    cal = 1'b1;
    tick(10);
    check_now("fail_after_timeouts", 5'b10110);

    // Calibration synchronized exactly on the timeout terminal cycle: RUN wins.
    cal = 1'b0;
    pulse_reset("reset_before_boundary");
    release_reset(n);
    e = n + 19;
    tick(19 + 61);
    cal = 1'b1;
    expect_at(e + 64, 1'b0, 1'b1, 1'b0, 2'd0);
    tick(10);

    // One cycle later than the terminal cycle: timeout wins, then RUN after HOLD.
    r = cyc;
    cal = 1'b0;
    expect_at(r + 3,  1'b1, 1'b0, 1'b0, 2'd1);
    expect_at(r + 19, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(19 + 62);
    cal = 1'b1;
    expect_at(r + 83,  1'b1, 1'b0, 1'b0, 2'd2);
    expect_at(r + 99,  1'b0, 1'b0, 1'b0, 2'd2);
    expect_at(r + 100, 1'b0, 1'b1, 1'b0, 2'd2);
    tick(25);

    // Calibration loss with retries exhausted goes straight to FAIL.
    r2 = cyc;
    cal = 1'b0;
    expect_at(r2 + 3, 1'b1, 1'b0, 1'b1, 2'd2);
    tick(15);
    check_now("fail_on_loss", 5'b10110);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending want=0 (next at cycle %0d)",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
